// File: rtl/beta_alu_pkg.sv
// Shared definitions for the Beta ALU scheduler: function codes, FSM states
// and the execute-length helper used when an operation is issued.
package beta_alu_pkg;

   localparam logic [3:0] ALU_FN_ADD   = 4'b0000;
   localparam logic [3:0] ALU_FN_SUB   = 4'b0001;
   localparam logic [3:0] ALU_FN_MUL   = 4'b0010;
   localparam logic [3:0] ALU_FN_AND   = 4'b1000;
   localparam logic [3:0] ALU_FN_XOR   = 4'b1010;
   localparam logic [3:0] ALU_FN_CMPEQ = 4'b0100;
   localparam logic [3:0] ALU_FN_CMPLT = 4'b0101;
   localparam logic [3:0] ALU_FN_CMPLE = 4'b0110;
   localparam logic [3:0] ALU_FN_SHL   = 4'b1100;
   localparam logic [3:0] ALU_FN_SHR   = 4'b1101;
   localparam logic [3:0] ALU_FN_SRA   = 4'b1110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Only the multiplier needs the long hold; every other code, including
   // unused ones, runs for the short execute length.
   function automatic int exec_cycles(input logic [3:0] fn, input int alu_n, input int mul_n);
      return (fn == ALU_FN_MUL) ? mul_n : alu_n;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The requester that did not win last time gets
// priority when both request; a lone requester always wins. Grant is purely
// combinational so it can drive a ready signal in the same cycle.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       en,
   output logic [1:0] grant
);

   // Grant one-hot (or zero when disabled or idle)
   always_comb begin
      grant[0] = en & req[0] & (~req[1] | last_grant);
      grant[1] = en & req[1] & (~req[0] | ~last_grant);
   end

endmodule

// File: rtl/beta_alu_sched.sv
// Shares one external Beta ALU between two requesters. A winning request is
// latched onto registered ALU inputs, held for ALU_CYCLES or MUL_CYCLES so the
// combinational multiplier can settle, then the ALU result is captured and
// returned to the owning requester with a valid/ready handshake.
// ALU_CYCLES and MUL_CYCLES must both be at least 1.
module beta_alu_sched
   import beta_alu_pkg::*;
#(
   parameter int ALU_CYCLES = 1,
   parameter int MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req0_fn,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req1_fn,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic [1:0]  resp_valid,
   input  logic [1:0]  resp_ready,
   output logic [31:0] resp_data,
   output logic [3:0]  alu_fn,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   output logic        busy
);

   localparam int MAX_CYCLES = (MUL_CYCLES > ALU_CYCLES) ? MUL_CYCLES : ALU_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             owner_reg, owner_next;
   logic             last_grant_reg, last_grant_next;
   logic [3:0]       alu_fn_reg, alu_fn_next;
   logic [31:0]      alu_a_reg, alu_a_next;
   logic [31:0]      alu_b_reg, alu_b_next;
   logic [31:0]      resp_data_reg, resp_data_next;
   logic [1:0]       resp_valid_reg, resp_valid_next;

   logic [1:0]       grant;
   logic [1:0]       hs;
   logic             arb_en;
   logic             sel;
   logic [3:0]       req_fn [2];
   logic [31:0]      req_a  [2];
   logic [31:0]      req_b  [2];

   // Requester ports gathered into arrays so the issue path is a plain index
   assign req_fn[0] = req0_fn;
   assign req_a[0]  = req0_a;
   assign req_b[0]  = req0_b;
   assign req_fn[1] = req1_fn;
   assign req_a[1]  = req1_a;
   assign req_b[1]  = req1_b;

   // Arbitration only happens while idle, so ready stays low in EXEC/RESP
   assign arb_en = (state_reg == IDLE);

   rr_arbiter2 u_arb (
      .req        (req_valid),
      .last_grant (last_grant_reg),
      .en         (arb_en),
      .grant      (grant)
   );

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_hs
         assign hs[gi] = req_valid[gi] & grant[gi];
      end
   endgenerate

   // Grant is one-hot, so requester 1 handshaking identifies the winner
   assign sel = hs[1];

   assign req_ready  = grant;
   assign resp_valid = resp_valid_reg;
   assign resp_data  = resp_data_reg;
   assign alu_fn     = alu_fn_reg;
   assign alu_a      = alu_a_reg;
   assign alu_b      = alu_b_reg;
   assign busy       = (state_reg != IDLE);

   // Next-state logic: issue on handshake, count down, capture, hand back
   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      alu_fn_next     = alu_fn_reg;
      alu_a_next      = alu_a_reg;
      alu_b_next      = alu_b_reg;
      resp_data_next  = resp_data_reg;
      resp_valid_next = resp_valid_reg;
      case (state_reg)
         IDLE: begin
            if (|hs) begin
               alu_fn_next     = req_fn[sel];
               alu_a_next      = req_a[sel];
               alu_b_next      = req_b[sel];
               owner_next      = sel;
               last_grant_next = sel;
               cnt_next        = CNT_W'(exec_cycles(req_fn[sel], ALU_CYCLES, MUL_CYCLES));
               state_next      = EXEC;
            end
         end
         EXEC: begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               resp_data_next  = alu_result;
               resp_valid_next = owner_reg ? 2'b10 : 2'b01;
               state_next      = RESP;
            end
         end
         RESP: begin
            // Only the owner's ready can retire the response
            if (resp_ready[owner_reg]) begin
               resp_valid_next = 2'b00;
               state_next      = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State registers; reset drops any in-flight operation silently
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         alu_fn_reg     <= '0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         resp_data_reg  <= '0;
         resp_valid_reg <= '0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
         alu_fn_reg     <= alu_fn_next;
         alu_a_reg      <= alu_a_next;
         alu_b_reg      <= alu_b_next;
         resp_data_reg  <= resp_data_next;
         resp_valid_reg <= resp_valid_next;
      end
   end

endmodule

// File: tb/tb_beta_alu_sched.sv
// Directed bench for beta_alu_sched with a behavioural Beta ALU on the
// alu_* / alu_result interface. Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at the same point.
module tb_beta_alu_sched;
   import beta_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req0_fn, req1_fn;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [31:0] resp_data;
   logic [3:0]  alu_fn;
   logic [31:0] alu_a, alu_b;
   logic [31:0] alu_result;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   beta_alu_sched #(.ALU_CYCLES(1), .MUL_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req0_fn    (req0_fn),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_fn    (req1_fn),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .alu_fn     (alu_fn),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .busy       (busy)
   );

   // Behavioural Beta ALU
   always_comb begin
      alu_result = 32'd0;
      case (alu_fn)
         ALU_FN_ADD:   alu_result = alu_a + alu_b;
         ALU_FN_SUB:   alu_result = alu_a - alu_b;
         ALU_FN_MUL:   alu_result = alu_a * alu_b;
         ALU_FN_AND:   alu_result = alu_a & alu_b;
         ALU_FN_XOR:   alu_result = alu_a ^ alu_b;
         ALU_FN_CMPEQ: alu_result = {31'd0, alu_a == alu_b};
         ALU_FN_CMPLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_FN_CMPLE: alu_result = {31'd0, $signed(alu_a) <= $signed(alu_b)};
         ALU_FN_SHL:   alu_result = alu_a << alu_b[4:0];
         ALU_FN_SHR:   alu_result = alu_a >> alu_b[4:0];
         ALU_FN_SRA:   alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         default:      alu_result = 32'd0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 2'b00;
      resp_ready = 2'b00;
      req0_fn = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
      req1_fn = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
      tick();
      tick();

      // ---------------- reset state
      chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_alu_fn", {28'd0, alu_fn}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      rst = 1'b0;
      tick();

      // ---------------- ADD from requester 0 (cycle k)
      req_valid = 2'b01; req0_fn = ALU_FN_ADD; req0_a = 32'd5; req0_b = 32'd7;
      resp_ready = 2'b11;
      settle();
      chk("add_req_ready_k", {30'd0, req_ready}, 32'd1);
      chk("add_busy_k", {31'd0, busy}, 32'd0);
      tick();                                   // k+1
      req_valid = 2'b00;
      settle();
      chk("add_busy_k1", {31'd0, busy}, 32'd1);
      chk("add_alu_a", alu_a, 32'd5);
      chk("add_alu_b", alu_b, 32'd7);
      chk("add_resp_valid_k1", {30'd0, resp_valid}, 32'd0);
      chk("add_req_ready_k1", {30'd0, req_ready}, 32'd0);
      tick();                                   // k+2
      chk("add_resp_valid_k2", {30'd0, resp_valid}, 32'd1);
      chk("add_resp_data", resp_data, 32'd12);
      chk("add_busy_k2", {31'd0, busy}, 32'd1);
      $display("txn ADD  req0 5+7 -> %0d", resp_data);
      tick();                                   // k+3
      chk("add_resp_valid_k3", {30'd0, resp_valid}, 32'd0);
      chk("add_busy_k3", {31'd0, busy}, 32'd0);

      // ---------------- SUB from requester 1
      req_valid = 2'b10; req1_fn = ALU_FN_SUB; req1_a = 32'd10; req1_b = 32'd3;
      settle();
      chk("sub_req_ready_k", {30'd0, req_ready}, 32'd2);
      tick();
      req_valid = 2'b00;
      settle();
      chk("sub_alu_fn", {28'd0, alu_fn}, 32'd1);
      tick();
      chk("sub_resp_valid", {30'd0, resp_valid}, 32'd2);
      chk("sub_resp_data", resp_data, 32'd7);
      $display("txn SUB  req1 10-3 -> %0d", resp_data);
      tick();

      // ---------------- MUL from requester 0: 4 EXEC cycles, result at k+5
      req_valid = 2'b01; req0_fn = ALU_FN_MUL; req0_a = 32'd6; req0_b = 32'd7;
      settle();
      chk("mul_req_ready_k", {30'd0, req_ready}, 32'd1);
      tick();
      req_valid = 2'b00; req0_fn = ALU_FN_XOR; req0_a = 32'hDEAD; req0_b = 32'hBEEF;
      for (int i = 1; i <= 4; i++) begin
         settle();
         chk($sformatf("mul_hold_fn_%0d", i), {28'd0, alu_fn}, 32'd2);
         chk($sformatf("mul_hold_a_%0d", i), alu_a, 32'd6);
         chk($sformatf("mul_hold_b_%0d", i), alu_b, 32'd7);
         chk($sformatf("mul_no_resp_%0d", i), {30'd0, resp_valid}, 32'd0);
         tick();
      end
      chk("mul_resp_valid", {30'd0, resp_valid}, 32'd1);
      chk("mul_resp_data", resp_data, 32'd42);
      $display("txn MUL  req0 6*7 -> %0d", resp_data);
      tick();
      chk("mul_done_busy", {31'd0, busy}, 32'd0);

      // ---------------- round robin after a fresh reset
      rst = 1'b1;
      settle();
      rst = 1'b0;
      req_valid = 2'b11;
      req0_fn = ALU_FN_ADD; req0_a = 32'd1; req0_b = 32'd1;
      req1_fn = ALU_FN_SUB; req1_a = 32'd9; req1_b = 32'd4;
      for (int g = 0; g < 4; g++) begin
         logic [1:0]  exp_g;
         logic [31:0] exp_d;
         exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
         exp_d = (g % 2 == 0) ? 32'd2 : 32'd5;
         settle();
         chk($sformatf("rr_grant_%0d", g), {30'd0, req_ready}, {30'd0, exp_g});
         tick();
         chk($sformatf("rr_exec_ready_%0d", g), {30'd0, req_ready}, 32'd0);
         tick();
         chk($sformatf("rr_resp_ready_%0d", g), {30'd0, req_ready}, 32'd0);
         chk($sformatf("rr_resp_valid_%0d", g), {30'd0, resp_valid}, {30'd0, exp_g});
         chk($sformatf("rr_resp_data_%0d", g), resp_data, exp_d);
         $display("txn RR   grant %0d -> %0d", g, resp_data);
         tick();
      end
      req_valid = 2'b00;
      tick();

      // ---------------- backpressure; last grant was requester 1
      req_valid = 2'b01; req0_fn = ALU_FN_ADD; req0_a = 32'd100; req0_b = 32'd23;
      resp_ready = 2'b00;
      settle();
      chk("bp_req_ready_k", {30'd0, req_ready}, 32'd1);
      tick();                                   // k+1
      req_valid = 2'b10; req1_fn = ALU_FN_XOR; req1_a = 32'hF0; req1_b = 32'h0F;
      tick();                                   // k+2: response appears
      for (int s = 0; s < 3; s++) begin
         resp_ready = (s == 1) ? 2'b10 : 2'b00; // non-owner ready must be ignored
         settle();
         chk($sformatf("bp_valid_%0d", s), {30'd0, resp_valid}, 32'd1);
         chk($sformatf("bp_data_%0d", s), resp_data, 32'd123);
         chk($sformatf("bp_pending_%0d", s), {30'd0, req_ready}, 32'd0);
         tick();
      end
      resp_ready = 2'b01;                       // release cycle
      settle();
      chk("bp_release_valid", {30'd0, resp_valid}, 32'd1);
      chk("bp_release_ready", {30'd0, req_ready}, 32'd0);
      $display("txn BP   req0 100+23 -> %0d", resp_data);
      tick();
      chk("bp_after_valid", {30'd0, resp_valid}, 32'd0);
      chk("bp_after_grant", {30'd0, req_ready}, 32'd2);
      resp_ready = 2'b11;
      tick();
      req_valid = 2'b00;
      settle();
      chk("bp_xor_alu_a", alu_a, 32'hF0);
      tick();
      chk("bp_xor_valid", {30'd0, resp_valid}, 32'd2);
      chk("bp_xor_data", resp_data, 32'hFF);
      $display("txn XOR  req1 F0^0F -> %0h", resp_data);
      tick();

      // ---------------- reset during the second EXEC cycle of a MUL
      req_valid = 2'b01; req0_fn = ALU_FN_MUL; req0_a = 32'd3; req0_b = 32'd5;
      tick();                                   // EXEC 1
      req_valid = 2'b00;
      tick();                                   // EXEC 2
      rst = 1'b1;
      settle();
      chk("mrst_alu_fn", {28'd0, alu_fn}, 32'd0);
      chk("mrst_alu_a", alu_a, 32'd0);
      chk("mrst_alu_b", alu_b, 32'd0);
      chk("mrst_resp_data", resp_data, 32'd0);
      chk("mrst_resp_valid", {30'd0, resp_valid}, 32'd0);
      chk("mrst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("mrst_no_stale_%0d", c), {30'd0, resp_valid}, 32'd0);
      end
      req_valid = 2'b11;
      req0_fn = ALU_FN_ADD; req0_a = 32'd1; req0_b = 32'd1;
      settle();
      chk("mrst_first_winner", {30'd0, req_ready}, 32'd1);
      tick();
      req_valid = 2'b00;
      tick();
      chk("mrst_resp_data", resp_data, 32'd2);
      $display("txn POST req0 1+1 -> %0d", resp_data);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
